fsm_burst_rd: RTL and testbench

//  Parametrised burst-read controller, next generation of the single-beat go/ws read FSM.
//  - Accepts a request (go + len) and issues len+1 read strobes (rd), one per beat.
//  - Honours a per-beat wait-state retry (ws), signals completion (ds) and, optionally, retry timeout (err).
//  - All outputs are registered; there is no combinational input-to-output path.
//  - Sits between a requester and a slow peripheral read port.

---
 rtl/fsm_burst_rd.sv | 166 ++++++++++++++++
 tb/tb_fsm_burst_rd.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_burst_rd.sv
// Burst-read controller: a go/len request issues len+1 read strobes, one per beat, with per-beat ws retry.
// Build option: define FSM_BURST_RD_TMO_EN to add the WS_RETRY retry timeout and the ERR state.
module fsm_burst_rd #(
   parameter int LEN_W    = 4,
   parameter int WS_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic [LEN_W-1:0] len,
   input  logic             ws,
   output logic             rd,
   output logic             ds,
   output logic             last,
   output logic [LEN_W-1:0] beat,
   output logic             busy,
   output logic             err,
   output logic [2:0]       state_dbg
);

   // Request handshake: go acts as valid with an implicit ready of (state == IDLE);
   // go/len seen in any other state are dropped, never queued. ws is only looked at in DLY.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      DLY  = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic             rd_q, rd_d;
   logic             ds_q, ds_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;

`ifdef FSM_BURST_RD_TMO_EN
   localparam int                 RETRY_W    = $clog2(WS_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(WS_RETRY - 1);

   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               err_q, err_d;
`else
   logic unused_ws_retry;
   assign unused_ws_retry = (WS_RETRY > 0);
`endif

   // State register plus the output flops, all on the same async active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         beat_q  <= '0;
         rd_q    <= 1'b0;
         ds_q    <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef FSM_BURST_RD_TMO_EN
         retry_q <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         rd_q    <= rd_d;
         ds_q    <= ds_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
`ifdef FSM_BURST_RD_TMO_EN
         retry_q <= retry_d;
         err_q   <= err_d;
`endif
      end
   end

   // Next-state and datapath decode
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      beat_d  = beat_q;
`ifdef FSM_BURST_RD_TMO_EN
      retry_d = retry_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef FSM_BURST_RD_TMO_EN
            retry_d = '0;
`endif
            if (go) begin
               state_d = READ;
               len_d   = len;
               beat_d  = '0;
            end
         end
         READ: begin
            state_d = DLY;
         end
         DLY: begin
            if (ws) begin
`ifdef FSM_BURST_RD_TMO_EN
               if (retry_q == RETRY_LAST) begin
                  state_d = ERR;
               end else begin
                  state_d = READ;
                  retry_d = retry_q + 1'b1;
               end
`else
               state_d = READ;
`endif
            end else if (beat_q != len_q) begin
               state_d = READ;
               beat_d  = beat_q + 1'b1;
`ifdef FSM_BURST_RD_TMO_EN
               retry_d = '0;
`endif
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
`ifdef FSM_BURST_RD_TMO_EN
         ERR: begin
            state_d = IDLE;
         end
`endif
         default: begin
            state_d = state_e'(3'bxxx);
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q
   always_comb begin
      rd_d   = (state_d == READ);
      ds_d   = (state_d == DONE);
      busy_d = (state_d != IDLE);
      last_d = rd_d && (beat_d == len_d);
`ifdef FSM_BURST_RD_TMO_EN
      err_d  = (state_d == ERR);
`endif
   end

   assign rd        = rd_q;
   assign ds        = ds_q;
   assign last      = last_q;
   assign beat      = beat_q;
   assign busy      = busy_q;
   assign state_dbg = state_q;
`ifdef FSM_BURST_RD_TMO_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

`ifndef SYNTHESIS
   a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) $onehot0({rd, ds, err}));
   a_last_rd:     assert property (@(posedge clk) disable iff (!rst_n) last |-> rd);
   a_beat_bound:  assert property (@(posedge clk) disable iff (!rst_n) busy |-> (beat <= len_q));
`endif

endmodule

// File: tb/tb_fsm_burst_rd.sv
// Bench for fsm_burst_rd: directed vector table, reset/timeout sequences and randomized bursts
// checked against a burst-level trace model (FSM_BURST_RD_TMO_EN selects the timeout model).
module tb_fsm_burst_rd;

   localparam int LW       = 4;
   localparam int WS_RETRY = 3;
   localparam int EW       = LW + 6;  // {chk_beat, rd, ds, last, busy, err, beat}

   logic          clk;
   logic          rst_n;
   logic          go;
   logic [LW-1:0] len;
   logic          ws;
   logic          rd;
   logic          ds;
   logic          last;
   logic [LW-1:0] beat;
   logic          busy;
   logic          err;
   logic [2:0]    dbg_state;

   int n_vec;
   int n_bad;

   logic [EW-1:0] exp_q[$];
   logic [LW+1:0] stim_q[$];

   typedef struct {
      logic          go;
      logic [LW-1:0] len;
      logic          ws;
      logic [EW-1:0] exp_v;
   } vec_t;

   vec_t tbl[$];

   fsm_burst_rd #(.LEN_W(LW), .WS_RETRY(WS_RETRY)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (go),
      .len       (len),
      .ws        (ws),
      .rd        (rd),
      .ds        (ds),
      .last      (last),
      .beat      (beat),
      .busy      (busy),
      .err       (err),
      .state_dbg (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- expected-output builders ----------------
   function automatic logic [EW-1:0] ex(input bit cb, input bit r, input bit d, input bit la,
                                        input bit b, input bit e, input int bt);
      logic [LW-1:0] bv;
      bv = LW'(bt);
      return {cb, r, d, la, b, e, bv};
   endfunction

   function automatic logic [EW-1:0] exp_idle();
      return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endfunction
   function automatic logic [EW-1:0] exp_rd(input int b, input bit la);
      return ex(1'b1, 1'b1, 1'b0, la, 1'b1, 1'b0, b);
   endfunction
   function automatic logic [EW-1:0] exp_dly(input int b);
      return ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, b);
   endfunction
   function automatic logic [EW-1:0] exp_done(input int b);
      return ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, b);
   endfunction
   function automatic logic [EW-1:0] exp_err(input int b);
      return ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, b);
   endfunction

   // ---------------- scoreboard compare ----------------
   task automatic check(input logic [EW-1:0] e, input string tag);
      logic [EW-2:0] act;
      logic [EW-2:0] mask;
      act  = {rd, ds, last, busy, err, beat};
      mask = e[EW-1] ? {(EW-1){1'b1}} : {5'b11111, {LW{1'b0}}};
      n_vec++;
      if ((act & mask) !== (e[EW-2:0] & mask)) begin
         n_bad++;
         $display("FAIL %s @%0t: got rd/ds/last/busy/err=%b%b%b%b%b beat=%0d, want %b%b%b%b%b beat=%0d%s (state=%0d)",
                  tag, $time, rd, ds, last, busy, err, beat,
                  e[EW-2], e[EW-3], e[EW-4], e[EW-5], e[EW-6], e[LW-1:0],
                  e[EW-1] ? "" : "(unchecked)", dbg_state);
      end
   endtask

   // ---------------- driver side ----------------
   function automatic void push(input logic g, input logic [LW-1:0] l, input logic w,
                                input logic [EW-1:0] e);
      stim_q.push_back({g, l, w});
      exp_q.push_back(e);
   endfunction

   function automatic void row(input logic g, input int l, input logic w, input logic [EW-1:0] e);
      vec_t v;
      v.go    = g;
      v.len   = LW'(l);
      v.ws    = w;
      v.exp_v = e;
      tbl.push_back(v);
   endfunction

   // Burst-level reference: one accept cycle, then per beat (READ, DLY) pairs repeated
   // for every ws retry, then DONE (or ERR when a beat exhausts its retries).
   // stuck < 0 picks a random retry count per beat; gap idle cycles precede the accept.
   function automatic void model_burst(input int l, input int stuck, input int gap, input bit hold);
      int   nret;
      int   tries;
      bit   failed;
      logic wsv;
      logic gv;
      for (int i = 0; i < gap; i++)
         push(1'b0, LW'($urandom), 1'($urandom), exp_idle());
      push(1'b1, LW'(l), 1'($urandom), exp_idle());
      failed = 1'b0;
      for (int b = 0; b <= l && !failed; b++) begin
         if (stuck >= 0) nret = stuck;
         else nret = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WS_RETRY)) : 0;
         tries = 0;
         while (1) begin
            gv = hold ? 1'b1 : 1'($urandom);
            push(gv, LW'($urandom), 1'($urandom), exp_rd(b, (b == l)));
            wsv = (tries < nret);
            gv  = hold ? 1'b1 : 1'($urandom);
            push(gv, LW'($urandom), wsv, exp_dly(b));
            if (!wsv) break;
            tries++;
`ifdef FSM_BURST_RD_TMO_EN
            if (tries == WS_RETRY) begin
               push(hold ? 1'b1 : 1'($urandom), LW'($urandom), 1'($urandom), exp_err(b));
               failed = 1'b1;
               break;
            end
`endif
         end
      end
      if (!failed)
         push(hold ? 1'b1 : 1'($urandom), LW'($urandom), 1'($urandom), exp_done(l));
   endfunction

   function automatic void idle_tail();
      push(1'b0, LW'($urandom), 1'($urandom), exp_idle());
   endfunction

   // One queue entry per cycle: compare at the falling edge, then drive that cycle's inputs
   task automatic run_q(input string tag);
      logic [LW+1:0] s;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check(exp_q.pop_front(), tag);
         s = stim_q.pop_front();
         {go, len, ws} = s;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      go    = 1'b0;
      len   = '0;
      ws    = 1'b0;

      // single beat, len=0
      row(1, 0, 0, exp_idle());
      row(0, 0, 0, exp_rd(0, 1));
      row(0, 0, 0, exp_dly(0));
      row(0, 0, 0, exp_done(0));
      row(0, 0, 0, exp_idle());
      // len=3 burst; go/len/ws noise in non-sampling states must be ignored
      row(1, 3, 0, exp_idle());
      row(1, 0, 1, exp_rd(0, 0));
      row(0, 7, 0, exp_dly(0));
      row(1, 15, 0, exp_rd(1, 0));
      row(0, 0, 0, exp_dly(1));
      row(0, 0, 1, exp_rd(2, 0));
      row(1, 2, 0, exp_dly(2));
      row(0, 0, 0, exp_rd(3, 1));
      row(0, 0, 0, exp_dly(3));
      row(1, 5, 1, exp_done(3));
      row(0, 0, 0, exp_idle());
      // len=1, two wait states on beat 0
      row(1, 1, 0, exp_idle());
      row(0, 0, 0, exp_rd(0, 0));
      row(0, 0, 1, exp_dly(0));
      row(0, 0, 0, exp_rd(0, 0));
      row(0, 0, 1, exp_dly(0));
      row(0, 0, 0, exp_rd(0, 0));
      row(0, 0, 0, exp_dly(0));
      row(0, 0, 0, exp_rd(1, 1));
      row(0, 0, 0, exp_dly(1));
      row(0, 0, 0, exp_done(1));
      row(0, 0, 0, exp_idle());
      // go held high, len=0, len changed mid-burst
      row(1, 0, 0, exp_idle());
      row(1, 5, 0, exp_rd(0, 1));
      row(1, 9, 0, exp_dly(0));
      row(1, 2, 0, exp_done(0));
      row(1, 0, 0, exp_idle());
      row(1, 0, 0, exp_rd(0, 1));
      row(0, 3, 0, exp_dly(0));
      row(0, 0, 0, exp_done(0));
      row(0, 0, 0, exp_idle());

      // reset state
      repeat (2) @(negedge clk);
      check(exp_done(0) & {1'b1, {(EW-1){1'b0}}}, "reset_state");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         check(tbl[i].exp_v, $sformatf("tbl[%0d]", i));
         go  = tbl[i].go;
         len = tbl[i].len;
         ws  = tbl[i].ws;
      end

      // ws stuck high on a len=2 burst: timeout build errors out, default build keeps retrying
      model_burst(2, 5, 0, 1'b0);
      idle_tail();
      run_q("ws_stuck");

      // async reset in DLY of beat 2, then restart from beat 0
      @(negedge clk);
      check(exp_idle(), "pre_reset_idle");
      go  = 1'b1;
      len = 4'd3;
      ws  = 1'b0;
      @(negedge clk);
      go  = 1'b0;
      repeat (5) @(negedge clk);
      check(exp_dly(2), "pre_reset_dly2");
      #2;
      rst_n = 1'b0;
      go    = 1'b1;
      #1;
      check(exp_done(0) & {1'b1, {(EW-1){1'b0}}}, "reset_async");
      @(negedge clk);
      check(exp_done(0) & {1'b1, {(EW-1){1'b0}}}, "reset_held");
      go    = 1'b0;
      rst_n = 1'b1;
      model_burst(1, 0, 0, 1'b0);
      idle_tail();
      run_q("after_reset");

      // randomized bursts against the trace model
      for (int k = 0; k < 40; k++) begin
         bit hold;
         int gap;
         hold = ($urandom_range(0, 3) == 0);
         gap  = hold ? 0 : int'($urandom_range(0, 2));
         model_burst(int'($urandom_range(0, (1 << LW) - 1)), -1, gap, hold);
      end
      idle_tail();
      run_q("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
